// File: rtl/scumv_host_packet_framer.sv
// Host-side framer: sends "asc+"/"stl+" prefixed commands to a UART TX byte port and gathers the reply.
// Optional response timeout is enabled by defining SCUMV_FRAMER_TIMEOUT_EN.
module scumv_host_packet_framer #(
  parameter int CLOCK_FREQ     = 100_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int ASC_LEN        = 22,
  parameter int STL_LEN        = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_sel,
  input  logic [175:0] cmd_payload,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] resp_data,
  output logic         resp_valid,
  output logic         resp_timeout,
  output logic         busy,
  output logic [7:0]   stray_count,
  output logic [2:0]   debug_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PREFIX    = 3'd1,
    PAYLOAD   = 3'd2,
    WAIT_RESP = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [4:0] ASC_LAST = 5'(ASC_LEN - 1);
  localparam logic [4:0] STL_LAST = 5'(STL_LEN - 1);

  state_t         state_q, state_d;
  logic           sel_q, sel_d;
  logic [4:0]     byte_cnt_q, byte_cnt_d;
  logic [127:0]   resp_q, resp_d;
  logic [7:0]     stray_q, stray_d;
  logic [175:0]   payload_q;
  logic [7:0]     pay_byte;
  logic [4:0]     pay_last, resp_last;
  logic           hs;

`ifdef SCUMV_FRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]  timer_q, timer_d;
  logic           tmo_q, tmo_d;
`endif

  // Clock frequency only documents the timeout scaling.
  logic unused_cfg;
  assign unused_cfg = ^{CLOCK_FREQ, TIMEOUT_CYCLES};

  function automatic logic [7:0] prefix_byte(input logic stl, input logic [1:0] idx);
    logic [31:0] p;
    p = stl ? 32'h2B6C7473 : 32'h2B637361;
    return p[8*idx +: 8];
  endfunction

  assign hs        = tx_valid && tx_ready;
  assign pay_last  = sel_q ? STL_LAST : ASC_LAST;
  assign resp_last = sel_q ? STL_LAST : 5'd0;

  always_comb begin
    pay_byte = '0;
    for (int k = 0; k < ASC_LEN; k++) begin
      if (byte_cnt_q == 5'(k)) pay_byte = payload_q[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      byte_cnt_q <= '0;
      resp_q     <= '0;
      stray_q    <= '0;
`ifdef SCUMV_FRAMER_TIMEOUT_EN
      timer_q    <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      byte_cnt_q <= byte_cnt_d;
      resp_q     <= resp_d;
      stray_q    <= stray_d;
`ifdef SCUMV_FRAMER_TIMEOUT_EN
      timer_q    <= timer_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && cmd_valid) payload_q <= cmd_payload;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    byte_cnt_d = byte_cnt_q;
    resp_d     = resp_q;
    stray_d    = stray_q;
`ifdef SCUMV_FRAMER_TIMEOUT_EN
    timer_d    = timer_q;
    tmo_d      = tmo_q;
`endif
    // Any rx byte outside the response window is discarded but counted.
    if (rx_valid && state_q != WAIT_RESP && stray_q != 8'hFF) stray_d = stray_q + 8'd1;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          sel_d      = cmd_sel;
          resp_d     = '0;
          byte_cnt_d = '0;
`ifdef SCUMV_FRAMER_TIMEOUT_EN
          tmo_d      = 1'b0;
`endif
          state_d    = PREFIX;
        end
      end
      PREFIX: begin
        if (hs) begin
          if (byte_cnt_q == 5'd3) begin
            byte_cnt_d = '0;
            state_d    = PAYLOAD;
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end
      PAYLOAD: begin
        if (hs) begin
          if (byte_cnt_q == pay_last) begin
            byte_cnt_d = '0;
`ifdef SCUMV_FRAMER_TIMEOUT_EN
            timer_d    = '0;
`endif
            state_d    = WAIT_RESP;
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end
      WAIT_RESP: begin
        if (rx_valid) begin
          for (int k = 0; k < 16; k++) begin
            if (byte_cnt_q == 5'(k)) resp_d[8*k +: 8] = rx_data;
          end
          byte_cnt_d = byte_cnt_q + 5'd1;
`ifdef SCUMV_FRAMER_TIMEOUT_EN
          timer_d    = '0;
`endif
          if (byte_cnt_q == resp_last) state_d = DONE;
        end
`ifdef SCUMV_FRAMER_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    case (state_q)
      IDLE:    cmd_ready = 1'b1;
      PREFIX: begin
        tx_valid = 1'b1;
        tx_data  = prefix_byte(sel_q, byte_cnt_q[1:0]);
      end
      PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = pay_byte;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_data   = resp_q;
  assign stray_count = stray_q;
  assign debug_state = state_q;
`ifdef SCUMV_FRAMER_TIMEOUT_EN
  assign resp_timeout = tmo_q;
`else
  assign resp_timeout = 1'b0;
`endif

endmodule

// File: doc/scumv_host_packet_framer.md
Name: scumv_host_packet_framer

Overview:
- Initiator-side counterpart of the controller's UART protocol handler; lives in FPGA test/loopback harnesses.
- Turns a parallel command into the "asc+"/"stl+" byte stream: 4-byte prefix, then payload.
- Drives that stream into a UART TX byte port, then collects the response bytes from a UART RX byte port into a parallel response register.
- Reports completion or timeout.

Parameters:
- CLOCK_FREQ, 100_000_000, clock frequency in Hz (documentation / timeout scaling only)
- TIMEOUT_CYCLES, 1_000_000, maximum cycles allowed between response bytes before abort
- ASC_LEN, 22, ASC payload byte count
- STL_LEN, 16, STL payload byte count; also the STL response byte count

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  framer idle and able to accept a command
- cmd_sel  in  1  0=ASC, 1=STL
- cmd_payload  in  176  payload; byte k = bits [8k+7:8k], sent k=0 first; STL uses bytes 0..15 only
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte
- rx_data  in  8  byte from UART RX
- rx_valid  in  1  single-cycle strobe, rx_data valid (no backpressure)
- resp_data  out  128  collected response; byte k at [8k+7:8k]; ASC response occupies byte 0, upper bytes zero
- resp_valid  out  1  one-cycle pulse: response complete or timed out
- resp_timeout  out  1  qualifies resp_valid; 1 = aborted by timeout
- busy  out  1  state != IDLE
- stray_count  out  8  count of rx bytes received while not in WAIT_RESP; saturates at 255
- debug_state  out  3  current state encoding

Behaviour:
- Reset (async assert, sync release): state IDLE, cmd_ready=1, tx_valid=0, tx_data=0, resp_data=0, resp_valid=0, resp_timeout=0, busy=0, stray_count=0, all counters 0.
- State encodings: IDLE=0, PREFIX=1, PAYLOAD=2, WAIT_RESP=3, DONE=4.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_sel and cmd_payload; clear resp_data; byte_cnt=0; go to PREFIX.
- PREFIX:
  - tx_valid=1; tx_data = prefix[byte_cnt].
  - ASC prefix: 61 73 63 2B. STL prefix: 73 74 6C 2B.
  - Each tx_valid&&tx_ready advances byte_cnt. After byte 3 accepted: byte_cnt=0, go to PAYLOAD.
- PAYLOAD:
  - tx_valid=1; tx_data = latched byte[byte_cnt].
  - On handshake, byte_cnt++. After byte LEN-1 is accepted (LEN = ASC_LEN or STL_LEN by cmd_sel): byte_cnt=0, timer=0, go to WAIT_RESP.
  - tx_data stays stable while tx_valid && !tx_ready.
- Transmit has no gaps: the next byte is presented the cycle after a handshake. Prefix plus payload takes exactly 4+LEN handshakes.
- WAIT_RESP:
  - tx_valid=0. Expected count is 1 for ASC and STL_LEN for STL.
  - On rx_valid: store rx_data at resp_data byte[byte_cnt], byte_cnt++, timer=0.
  - When the last expected byte is stored: go to DONE.
  - Otherwise timer++ each cycle. Timeout behaviour: see Optional Feature.
- DONE:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - resp_data holds its value until the next command is accepted.
- rx_valid in IDLE, PREFIX, PAYLOAD or DONE: byte discarded, stray_count++ (saturating at 255, no wrap).
- rx_valid in the same cycle as the final tx handshake: state is still PAYLOAD, so the byte counts as stray.
- cmd_valid is ignored whenever the state is not IDLE; cmd_ready=0 in those states.
- reset_n asserted mid-transfer: immediate return to reset values. A partially sent frame is not completed; the downstream handler resyncs on its prefix detector.
- Counters: byte_cnt is 5 bits; timer is $clog2(TIMEOUT_CYCLES+1) bits.

Optional Feature:
- Macro: SCUMV_FRAMER_TIMEOUT_EN
- Defined:
  - In WAIT_RESP, if timer reaches TIMEOUT_CYCLES with no rx byte: go to DONE with resp_timeout=1.
  - resp_data keeps the partial bytes received so far.
  - resp_timeout is cleared when the next command is accepted.
- Undefined:
  - No timer logic; WAIT_RESP waits indefinitely.
  - resp_timeout is tied to 0.

Test Plan:
- ASC command, payload bytes 0x00..0x15, tx_ready=1 -> tx stream is 61 73 63 2B 00 01 … 15 (26 bytes, back-to-back). rx byte 0xA5 -> resp_valid pulse, resp_data=0x…00A5, resp_timeout=0.
- STL command, payload bytes 0x10..0x1F, tx_ready toggling 1/0 every cycle -> 73 74 6C 2B 10..1F with no dropped or repeated bytes. 16 rx bytes 0xF0..0xFF -> resp_data byte0=F0 … byte15=FF.
- cmd_valid held high across a whole transaction -> second command accepted only after DONE. rx bytes sent during PAYLOAD -> stray_count increments by exactly that number.
- With SCUMV_FRAMER_TIMEOUT_EN and TIMEOUT_CYCLES=100: STL command, 3 rx bytes then silence -> resp_valid with resp_timeout=1, 100 cycles after the last byte; resp_data bytes 0..2 set, rest 0.
- reset_n pulsed low during payload byte 10 -> tx_valid=0 and state IDLE immediately. Next ASC command transmits a full, correct frame.
- 300 rx strobes while IDLE -> stray_count saturates at 255.
